// File: rtl/collision_pkg.sv
// Shared helpers for the collision matrix: pair indexing, pair count and hold-off counter sizing.
// The optional per-pair hit counter is enabled with the COLLISION_HIT_COUNT_EN macro.
package collision_pkg;

  localparam int HOLDOFF_W   = 4;
  localparam int DEF_NUM_OBJ = 4;

  function automatic int num_pairs(input int n);
    return n * (n - 1) / 2;
  endfunction

  // Row-major upper-triangle index for object pair (i, j), i < j.
  function automatic int pair_idx(input int i, input int j, input int n);
    return i * (2 * n - i - 1) / 2 + (j - i - 1);
  endfunction

  function automatic int sel_width(input int pairs);
    return (pairs > 1) ? $clog2(pairs) : 1;
  endfunction

  typedef logic [num_pairs(DEF_NUM_OBJ)-1:0] pairVec_t;

endpackage

// File: rtl/collision_if.sv
// Draw-flag / collision-result bundle between object blocks, the collision matrix and its consumers.
// hit_sel/hit_count only exist when COLLISION_HIT_COUNT_EN is defined.
interface collision_if import collision_pkg::*; #(
  parameter int NUM_OBJ = 4
`ifdef COLLISION_HIT_COUNT_EN
  , parameter int HIT_CNT_W = 8
`endif
) ();

  localparam int NUM_PAIRS = num_pairs(NUM_OBJ);

  logic                 startOfFrame;
  logic [NUM_OBJ-1:0]   draw_vec;
  logic [NUM_PAIRS-1:0] pair_mask;
  logic [NUM_PAIRS-1:0] collision_frame;
  logic [NUM_PAIRS-1:0] collision_pulse;
  logic                 any_collision;
`ifdef COLLISION_HIT_COUNT_EN
  logic [sel_width(NUM_PAIRS)-1:0] hit_sel;
  logic [HIT_CNT_W-1:0]            hit_count;
`endif

  modport master (
    output startOfFrame, draw_vec, pair_mask,
    input  collision_frame, collision_pulse, any_collision
`ifdef COLLISION_HIT_COUNT_EN
    , output hit_sel
    , input  hit_count
`endif
  );

  modport slave (
    input  startOfFrame, draw_vec, pair_mask,
    output collision_frame, collision_pulse, any_collision
`ifdef COLLISION_HIT_COUNT_EN
    , input  hit_sel
    , output hit_count
`endif
  );

endinterface

// File: rtl/collision_pair_cell.sv
// Per-pair state: frame accumulator, pulse flop, frame hold-off counter and optional saturating hit counter.
// The hit counter exists only when COLLISION_HIT_COUNT_EN is defined.
module collision_pair_cell import collision_pkg::*; #(
  parameter int HOLDOFF_FRAMES = 2
`ifdef COLLISION_HIT_COUNT_EN
  , parameter int HIT_CNT_W = 8
`endif
) (
  input  logic clk,
  input  logic resetN,
  input  logic startOfFrame,
  input  logic hit,
  output logic acc,
  output logic pulse
`ifdef COLLISION_HIT_COUNT_EN
  , output logic [HIT_CNT_W-1:0] hitCount
`endif
);

  localparam logic [HOLDOFF_W-1:0] HOLD_INIT = HOLDOFF_W'(HOLDOFF_FRAMES);

  logic [HOLDOFF_W-1:0] holdCnt;
  logic                 pulsedFrame;
  logic                 pulseNext;

  always_comb begin
    pulseNext = hit & ~acc & (holdCnt == '0);
  end

  // The frame that produced a pulse does not count toward the hold-off, so the
  // pair stays silent for HOLDOFF_FRAMES whole frames afterwards.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc         <= 1'b0;
      pulse       <= 1'b0;
      holdCnt     <= '0;
      pulsedFrame <= 1'b0;
    end else begin
      pulse <= pulseNext;

      if (startOfFrame)   acc <= 1'b0;
      else if (hit)       acc <= 1'b1;

      if (pulseNext)
        holdCnt <= HOLD_INIT;
      else if (startOfFrame && !pulsedFrame && (holdCnt != '0))
        holdCnt <= holdCnt - 1'b1;

      if (startOfFrame)   pulsedFrame <= 1'b0;
      else if (pulseNext) pulsedFrame <= 1'b1;
    end
  end

`ifdef COLLISION_HIT_COUNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      hitCount <= '0;
    else if (pulse && (hitCount != '1))
      hitCount <= hitCount + 1'b1;
  end
`endif

endmodule

// File: rtl/collision_matrix.sv
// Per-frame pairwise collision detector: decodes pair hits from draw flags, publishes per-frame results
// at startOfFrame and emits hold-off-limited pulses. Optional hit counters via COLLISION_HIT_COUNT_EN.
module collision_matrix import collision_pkg::*; #(
  parameter int NUM_OBJ        = 4,
  parameter int HOLDOFF_FRAMES = 2
`ifdef COLLISION_HIT_COUNT_EN
  , parameter int HIT_CNT_W    = 8
`endif
) (
  input logic        clk,
  input logic        resetN,
  collision_if.slave bus
);

  localparam int NUM_PAIRS = num_pairs(NUM_OBJ);

  logic [NUM_PAIRS-1:0] hitVec;
  logic [NUM_PAIRS-1:0] accVec;
  logic [NUM_PAIRS-1:0] pulseVec;
  logic [NUM_PAIRS-1:0] frameReg;
  logic                 anyReg;

  for (genvar i = 0; i < NUM_OBJ - 1; i++) begin : g_row
    for (genvar j = i + 1; j < NUM_OBJ; j++) begin : g_col
      localparam int P = pair_idx(i, j, NUM_OBJ);
      assign hitVec[P] = bus.draw_vec[i] & bus.draw_vec[j] & bus.pair_mask[P];
    end
  end

`ifdef COLLISION_HIT_COUNT_EN
  localparam int SEL_W = sel_width(NUM_PAIRS);

  // Padded to the full select range so out-of-range selects read back zero.
  logic [HIT_CNT_W-1:0] cntArr [2**SEL_W];
  logic [HIT_CNT_W-1:0] hitCountReg;

  for (genvar p = NUM_PAIRS; p < 2**SEL_W; p++) begin : g_pad
    assign cntArr[p] = '0;
  end
`endif

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    collision_pair_cell #(
      .HOLDOFF_FRAMES(HOLDOFF_FRAMES)
`ifdef COLLISION_HIT_COUNT_EN
      , .HIT_CNT_W(HIT_CNT_W)
`endif
    ) u_cell (
      .clk         (clk),
      .resetN      (resetN),
      .startOfFrame(bus.startOfFrame),
      .hit         (hitVec[p]),
      .acc         (accVec[p]),
      .pulse       (pulseVec[p])
`ifdef COLLISION_HIT_COUNT_EN
      , .hitCount  (cntArr[p])
`endif
    );
  end

  // A hit on the strobe cycle still belongs to the frame being closed.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frameReg <= '0;
      anyReg   <= 1'b0;
    end else if (bus.startOfFrame) begin
      frameReg <= accVec | hitVec;
      anyReg   <= |(accVec | hitVec);
    end
  end

`ifdef COLLISION_HIT_COUNT_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      hitCountReg <= '0;
    else
      hitCountReg <= cntArr[bus.hit_sel];
  end

  assign bus.hit_count = hitCountReg;
`endif

  assign bus.collision_frame = frameReg;
  assign bus.collision_pulse = pulseVec;
  assign bus.any_collision   = anyReg;

endmodule

// File: tb/tb_collision_matrix.sv
// Directed bench for collision_matrix (NUM_OBJ=4, HOLDOFF_FRAMES=2); the hit-counter scenario runs
// on a second instance with HOLDOFF_FRAMES=0 when COLLISION_HIT_COUNT_EN is defined.
module tb_collision_matrix;
  import collision_pkg::*;

  logic clk = 1'b0;
  logic resetN;
  int   checks   = 0;
  int   failures = 0;
  pairVec_t seen;

  always #5 clk = ~clk;

  collision_if #(.NUM_OBJ(4)) bus ();
  collision_matrix #(.NUM_OBJ(4), .HOLDOFF_FRAMES(2)) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

`ifdef COLLISION_HIT_COUNT_EN
  collision_if #(.NUM_OBJ(4), .HIT_CNT_W(8)) bus2 ();
  collision_matrix #(.NUM_OBJ(4), .HOLDOFF_FRAMES(0), .HIT_CNT_W(8)) dut2 (
    .clk(clk), .resetN(resetN), .bus(bus2)
  );
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof();
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
  endtask

  initial begin
    resetN           = 1'b0;
    bus.startOfFrame = 1'b0;
    bus.draw_vec     = 4'b0000;
    bus.pair_mask    = 6'h3F;
`ifdef COLLISION_HIT_COUNT_EN
    bus.hit_sel       = '0;
    bus2.startOfFrame = 1'b0;
    bus2.draw_vec     = 4'b0000;
    bus2.pair_mask    = 6'h3F;
    bus2.hit_sel      = '0;
`endif
    #12;
    chk("rst_frame", 32'(bus.collision_frame), 32'h00);
    chk("rst_pulse", 32'(bus.collision_pulse), 32'h00);
    chk("rst_any",   32'(bus.any_collision),   32'h0);
    @(negedge clk);
    resetN = 1'b1;
    tick();

    // 1: idle frames
    repeat (3) tick();
    sof();
    repeat (2) tick();
    chk("idle_frame", 32'(bus.collision_frame), 32'h00);
    chk("idle_any",   32'(bus.any_collision),   32'h0);
    chk("idle_pulse", 32'(bus.collision_pulse), 32'h00);

    // 2: pair 0 overlap for 5 cycles in frame 1
    bus.draw_vec = 4'b0011;
    tick();
    chk("f1_first_pulse", 32'(bus.collision_pulse), 32'h01);
    seen = '0;
    repeat (4) begin
      tick();
      seen |= bus.collision_pulse;
    end
    chk("f1_single_pulse", 32'(seen), 32'h00);
    bus.draw_vec = 4'b0000;
    tick();
    sof();
    chk("f1_frame", 32'(bus.collision_frame), 32'h01);
    chk("f1_any",   32'(bus.any_collision),   32'h1);

    // 3: same overlap in frames 2..4, hold-off silences frames 2 and 3
    for (int f = 2; f <= 4; f++) begin
      seen = '0;
      tick();
      bus.draw_vec = 4'b0011;
      repeat (3) begin
        tick();
        seen |= bus.collision_pulse;
      end
      bus.draw_vec = 4'b0000;
      tick();
      seen |= bus.collision_pulse;
      sof();
      chk($sformatf("f%0d_frame", f),  32'(bus.collision_frame), 32'h01);
      chk($sformatf("f%0d_pulses", f), 32'(seen), (f == 4) ? 32'h01 : 32'h00);
    end
    repeat (2) tick();
    sof();
    chk("f5_frame", 32'(bus.collision_frame), 32'h00);
    chk("f5_any",   32'(bus.any_collision),   32'h0);

    // 4: pair 5 overlap only on the strobe cycle
    bus.draw_vec     = 4'b1100;
    bus.startOfFrame = 1'b1;
    tick();
    bus.startOfFrame = 1'b0;
    bus.draw_vec     = 4'b0000;
    chk("sofhit_pulse", 32'(bus.collision_pulse), 32'h20);
    chk("sofhit_frame", 32'(bus.collision_frame), 32'h20);
    chk("sofhit_any",   32'(bus.any_collision),   32'h1);
    tick();
    chk("sofhit_pulse_end", 32'(bus.collision_pulse), 32'h00);
    repeat (2) tick();
    sof();
    chk("sofhit_next_frame", 32'(bus.collision_frame), 32'h00);

    // 5: pair 3 masked, then restored, then mask dropped after accumulation
    bus.pair_mask = 6'h37;
    bus.draw_vec  = 4'b0110;
    seen = '0;
    repeat (3) begin
      tick();
      seen |= bus.collision_pulse;
    end
    chk("masked_pulse", 32'(seen), 32'h00);
    bus.draw_vec = 4'b0000;
    tick();
    sof();
    chk("masked_frame", 32'(bus.collision_frame), 32'h00);
    bus.pair_mask = 6'h3F;
    bus.draw_vec  = 4'b0110;
    tick();
    chk("unmask_pulse", 32'(bus.collision_pulse), 32'h08);
    bus.draw_vec = 4'b0000;
    tick();
    sof();
    chk("unmask_frame", 32'(bus.collision_frame), 32'h08);
    bus.draw_vec = 4'b0110;
    tick();
    chk("holdoff_pulse", 32'(bus.collision_pulse), 32'h00);
    bus.pair_mask = 6'h37;
    tick();
    bus.draw_vec = 4'b0000;
    tick();
    sof();
    chk("maskdrop_frame", 32'(bus.collision_frame), 32'h08);
    bus.pair_mask = 6'h3F;

    // 6: reset mid-frame after an overlap
    bus.draw_vec = 4'b0011;
    tick();
    chk("prereset_pulse", 32'(bus.collision_pulse), 32'h01);
    #2 resetN = 1'b0;
    #1;
    chk("midrst_frame", 32'(bus.collision_frame), 32'h00);
    chk("midrst_pulse", 32'(bus.collision_pulse), 32'h00);
    chk("midrst_any",   32'(bus.any_collision),   32'h0);
    bus.draw_vec = 4'b0000;
    #2 resetN = 1'b1;
    repeat (2) tick();
    sof();
    chk("postrst_frame", 32'(bus.collision_frame), 32'h00);
    chk("postrst_any",   32'(bus.any_collision),   32'h0);
    bus.draw_vec = 4'b0011;
    tick();
    chk("postrst_pulse", 32'(bus.collision_pulse), 32'h01);
    bus.draw_vec = 4'b0000;
    tick();

`ifdef COLLISION_HIT_COUNT_EN
    // 7: saturating hit counter on pair 2 (objects 0 and 3), no hold-off
    bus2.hit_sel = 3'd2;
    for (int f = 0; f < 300; f++) begin
      bus2.draw_vec = 4'b1001;
      tick();
      bus2.draw_vec     = 4'b0000;
      bus2.startOfFrame = 1'b1;
      tick();
      bus2.startOfFrame = 1'b0;
    end
    repeat (2) tick();
    chk("hitcnt_sat", 32'(bus2.hit_count), 32'hFF);
    bus2.hit_sel = 3'd7;
    tick();
    chk("hitcnt_oor", 32'(bus2.hit_count), 32'h00);
    bus2.hit_sel = 3'd5;
    tick();
    chk("hitcnt_other", 32'(bus2.hit_count), 32'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
